// File: rtl/mdarray_pkg.sv
// rtl/mdarray_pkg.sv - shared constants, state encoding and coordinate type for the array scanner
package mdarray_pkg;

    localparam int DATA_W  = 8;
    localparam int RD_LAT  = 2;
    localparam int COORD_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] slc;
        logic [COORD_W-1:0] row;
        logic [COORD_W-1:0] col;
    } coord_t;

    // Raster step: col fastest, carries ripple into row then slc; all wrap at lim.
    function automatic coord_t coord_next(input coord_t c, input coord_t lim);
        coord_t n;
        n = c;
        if (c.col != lim.col) begin
            n.col = c.col + COORD_W'(1);
        end else begin
            n.col = '0;
            if (c.row != lim.row) begin
                n.row = c.row + COORD_W'(1);
            end else begin
                n.row = '0;
                n.slc = (c.slc != lim.slc) ? c.slc + COORD_W'(1) : '0;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/mdarray_scanner_if.sv
// rtl/mdarray_scanner_if.sv - memory address/read-data and output stream bundle
interface mdarray_scanner_if #(
    parameter int W = 2
);
    import mdarray_pkg::*;

    logic [W:0]        col;
    logic [W:0]        row;
    logic [W:0]        slc;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    modport master (
        output col, row, slc,
        input  mem_data,
        output m_data, m_valid, m_last,
        input  m_ready
    );

    modport slave (
        input  col, row, slc,
        output mem_data,
        input  m_data, m_valid, m_last,
        output m_ready
    );

endinterface

// File: rtl/mdarray_fifo.sv
// rtl/mdarray_fifo.sv - show-ahead FIFO carrying read data plus its last-element tag
module mdarray_fifo #(
    parameter  int WIDTH = 9,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_en) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mdarray_scanner.sv
// rtl/mdarray_scanner.sv - raster-order read sequencer for the array memory with backpressured output stream
module mdarray_scanner
    import mdarray_pkg::*;
#(
    parameter int W     = 2,
    parameter int NC    = 4,
    parameter int NR    = 4,
    parameter int NS    = 4,
    parameter int DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    mdarray_scanner_if.master   bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam coord_t LAST = '{
        slc: COORD_W'(NS - 1),
        row: COORD_W'(NR - 1),
        col: COORD_W'(NC - 1)
    };

    state_t              state;
    coord_t              cur;
    logic [RD_LAT-1:0]   vld;
    logic [RD_LAT-1:0]   lst;
    logic [CNT_W-1:0]    fifo_count;
    logic [DATA_W:0]     rd_word;
    logic                issue;
    logic                is_final;
    logic                rd_en;

    // Reserve a buffer slot for every read still in the memory pipeline so captures never overflow.
    assign issue    = (state == SCAN) &&
                      ((int'(fifo_count) + $countones(vld)) < DEPTH);
    assign is_final = (cur == LAST);
    assign rd_en    = bus.m_valid && bus.m_ready;

    assign bus.col     = cur.col[W:0];
    assign bus.row     = cur.row[W:0];
    assign bus.slc     = cur.slc[W:0];
    assign bus.m_valid = (fifo_count != '0);
    assign bus.m_data  = rd_word[DATA_W-1:0];
    assign bus.m_last  = rd_word[DATA_W] && bus.m_valid;

    mdarray_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .wr_en   (vld[RD_LAT-1]),
        .wr_data ({lst[RD_LAT-1], bus.mem_data}),
        .rd_en   (rd_en),
        .rd_data (rd_word),
        .count   (fifo_count)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            cur   <= '0;
            vld   <= '0;
            lst   <= '0;
        end else begin
            done <= 1'b0;
            vld  <= {vld[RD_LAT-2:0], issue};
            lst  <= {lst[RD_LAT-2:0], issue && is_final};
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SCAN;
                        busy  <= 1'b1;
                        cur   <= '0;
                    end
                end
                SCAN: begin
                    if (issue) begin
                        cur <= coord_next(cur, LAST);
                        if (is_final) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // The tagged element is the final one, so its handshake means nothing remains.
                    if (rd_en && bus.m_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mdarray_scanner.md
# mdarray_scanner

Read-side sequencer for the multi-dimensional array memory block. On a `start` pulse it walks every (slc, row, col) coordinate in raster order, drives the memory's address lines, and captures the read data the memory returns two cycles later. It delivers the data as a valid/ready stream with last-element marking and full backpressure. It sits between the array memory and any downstream consumer, such as a DMA or checksum engine.

## Interface
- `W`, 2: coordinate ports are `W+1` bits wide.
- `NC`, 4: column count, 1..2^(W+1).
- `NR`, 4: row count, 1..2^(W+1).
- `NS`, 4: slice count, 1..2^(W+1).
- `DEPTH`, 4: output buffer depth in entries, minimum 3.
- `clock`  in  1  sole clock; all logic is rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a scan; sampled only in IDLE.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse when the scan is complete.
- `col`, `row`, `slc`  out  W+1  memory address coordinates.
- `mem_data`  in  8  memory read data, valid 2 cycles after its address.
- `m_data`  out  8  stream data.
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready; a beat transfers when `m_valid && m_ready`.
- `m_last`  out  1  high with the final element (index NC*NR*NS-1).

## Operation
- States:
  - IDLE: `start` moves to SCAN.
  - SCAN: issues addresses; after the final address is issued, moves to DRAIN.
  - DRAIN: when in-flight is 0, the buffer is empty and the last beat has transferred, returns to IDLE with `done`=1 for that one cycle.
- Scan order: `col` increments fastest, then `row`, then `slc`.
  - `col` wraps NC-1→0 and carries into `row`.
  - `row` wraps NR-1→0 and carries into `slc`.
  - The scan ends after the address (NS-1, NR-1, NC-1).
- Issue rule: an address is issued in a cycle only when buffer occupancy + in-flight reads < DEPTH.
  - In-flight reads (0..2) are tracked by a 2-stage valid shift register.
  - When the issue rule fails, the counters hold and the address lines repeat the previous coordinate; that repeat is not a new issue.
- Capture: at the end of cycle k+2, `mem_data` is written to the buffer with a last-flag tag, where k is the issue cycle. Writes never overflow, by construction of the issue rule.
- Output: the buffer is show-ahead. `m_data`, `m_valid` and `m_last` come from the head entry.
- `start` while `busy` is ignored.
- A `start` in the `done` cycle is accepted, because the state is already IDLE.
- Total beats per scan are exactly NC*NR*NS, in raster order, with no drops or duplicates.
- During a scan the system must hold the memory's `wr` low. This block never writes the memory.

## Timing
- Reset values: state IDLE; `busy`, `done`, `m_valid`, `m_last` = 0; `col`, `row`, `slc` = 0; buffer empty; in-flight = 0. Reset applies asynchronously; release is synchronous to `clock`.
- Reset mid-scan: the scan is abandoned, buffered and in-flight data are discarded, and no `done` is produced. The next `start` begins again at (0,0,0).
- Start latency: `start` high in cycle 0 gives `busy`=1 and the first address in cycle 1. The first `m_valid` is in cycle 4.
- Throughput: with `m_ready` held high, one beat per cycle with no bubbles.
- With `m_ready` held high, `done` occurs one cycle after the last-beat handshake.
- `m_data` and `m_last` are stable while `m_valid && !m_ready`.
- `m_valid` never drops without a handshake.
- All outputs are registered except the show-ahead head of the buffer.

## Structure
- Package `mdarray_pkg` holds:
  - data width constant (8) and memory read latency constant (2);
  - the state enum (IDLE, SCAN, DRAIN);
  - a coordinate struct {slc, row, col}.
- Sub-module `mdarray_fifo`: synchronous show-ahead FIFO, 9 bits wide (data + last), parameter DEPTH, with `count` output and asynchronous active-low reset.
- The counters, issue gating, latency shift register and FSM live in the top module.

## Test plan
- Full scan, memory preloaded with mem[s][r][c] = 16s+4r+c, `m_ready`=1, `start` in cycle 0:
  - 64 consecutive beats with values 0..63;
  - first `m_valid` in cycle 4;
  - `m_last` only on value 63;
  - one-cycle `done` pulse, then `busy`=0.
- Backpressure: `m_ready`=0 for 12 cycles after beat 2 ->
  - no address issue while occupancy + in-flight = 4;
  - `m_data` held stable;
  - on resume, the sequence continues at value 3 with no loss.
- Random 50% `m_ready` over 3 scans -> each scan delivers exactly 0..63 in order, with one `done` per scan.
- `start` pulsed during SCAN and DRAIN is ignored. `start` in the `done` cycle begins a second scan with `busy` in the next cycle.
- `reset_n` asserted at beat 20 ->
  - `m_valid`, `busy` and coordinates go to 0 immediately, with no `done`;
  - the next scan begins at value 0.
- NC=NR=NS=1 -> a single beat with `m_last`=1, followed by `done`.
